// File: rtl/othello_move_engine.sv
// Othello move engine: reads a 64-square board word from the board BRAM,
// applies one move for one player (placement plus all flips), writes the
// result to a destination entry and reports legality and flip count.
module othello_move_engine #(
  parameter int MEM_SIZE = 256
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic [3:0]          i_src_addr,
  input  logic [3:0]          i_dst_addr,
  input  logic [2:0]          i_row,
  input  logic [2:0]          i_col,
  input  logic                i_player,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_legal,
  output logic [4:0]          o_flip_count,
  output logic                o_bram_we,
  output logic [3:0]          o_bram_addr,
  output logic [MEM_SIZE-1:0] o_bram_din,
  input  logic [MEM_SIZE-1:0] i_bram_dout
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_LOAD, S_SCAN, S_APPLY, S_WRITE, S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;

  logic [3:0]          r_dst_addr;
  logic [2:0]          r_row;
  logic [2:0]          r_col;
  logic                r_player;
  logic [MEM_SIZE-1:0] r_board;
  logic [63:0]         r_flip;
  logic [63:0]         r_pend;
  logic [2:0]          r_dir;
  logic [2:0]          r_cur_row;
  logic [2:0]          r_cur_col;
  logic                r_legal;
  logic [4:0]          r_flip_count;
  logic [3:0]          r_bram_addr;
  logic [MEM_SIZE-1:0] r_bram_din;

  logic signed [3:0]   w_dr;
  logic signed [3:0]   w_dc;
  logic signed [3:0]   w_cand_r;
  logic signed [3:0]   w_cand_c;
  logic                w_off;
  logic [5:0]          w_cand_idx;
  logic [5:0]          w_tgt_idx;
  logic [1:0]          w_cand_code;
  logic [1:0]          w_own_code;
  logic [1:0]          w_opp_code;
  logic                w_is_opp;
  logic                w_is_own;
  logic [1:0]          w_load_code;
  logic                w_occupied;

  // Count set bits of the flip mask; at most 18 can be set in a real game.
  function automatic logic [4:0] popcount64(input logic [63:0] m);
    logic [4:0] cnt;
    cnt = 5'd0;
    for (int i = 0; i < 64; i++) cnt = cnt + {4'd0, m[i]};
    return cnt;
  endfunction

  // Overwrite target and flipped squares with the player's code, upper bits cleared.
  function automatic logic [MEM_SIZE-1:0] build_board(input logic [MEM_SIZE-1:0] b,
                                                      input logic [63:0] flip,
                                                      input logic [5:0] tgt,
                                                      input logic [1:0] code);
    logic [MEM_SIZE-1:0] nb;
    nb = b;
    for (int s = 0; s < 64; s++) begin
      if (flip[s] || (6'(s) == tgt)) nb[4*s +: 4] = {2'b00, code};
    end
    return nb;
  endfunction

  // Direction step table: 0..7 = N, NE, E, SE, S, SW, W, NW (N decreases the row).
  always_comb begin
    w_dr = 4'sd0;
    w_dc = 4'sd0;
    case (r_dir)
      3'd0: begin w_dr = -4'sd1; w_dc =  4'sd0; end
      3'd1: begin w_dr = -4'sd1; w_dc =  4'sd1; end
      3'd2: begin w_dr =  4'sd0; w_dc =  4'sd1; end
      3'd3: begin w_dr =  4'sd1; w_dc =  4'sd1; end
      3'd4: begin w_dr =  4'sd1; w_dc =  4'sd0; end
      3'd5: begin w_dr =  4'sd1; w_dc = -4'sd1; end
      3'd6: begin w_dr =  4'sd0; w_dc = -4'sd1; end
      default: begin w_dr = -4'sd1; w_dc = -4'sd1; end
    endcase
  end

  assign w_cand_r    = $signed({1'b0, r_cur_row}) + w_dr;
  assign w_cand_c    = $signed({1'b0, r_cur_col}) + w_dc;
  assign w_off       = (w_cand_r < 4'sd0) || (w_cand_r > 4'sd7) ||
                       (w_cand_c < 4'sd0) || (w_cand_c > 4'sd7);
  assign w_cand_idx  = {w_cand_r[2:0], w_cand_c[2:0]};
  assign w_tgt_idx   = {r_row, r_col};
  assign w_cand_code = r_board[{w_cand_idx, 2'b00} +: 2];
  assign w_own_code  = r_player ? 2'b10 : 2'b01;
  assign w_opp_code  = r_player ? 2'b01 : 2'b10;
  // Reserved code 11 never matches either colour, so it behaves as empty.
  assign w_is_opp    = !w_off && (w_cand_code == w_opp_code);
  assign w_is_own    = !w_off && (w_cand_code == w_own_code);
  assign w_load_code = i_bram_dout[{w_tgt_idx, 2'b00} +: 2];
  assign w_occupied  = (w_load_code == 2'b01) || (w_load_code == 2'b10);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state and status outputs; the write strobe is masked by reset.
  always_comb begin
    w_next    = r_state;
    o_busy    = (r_state != S_IDLE);
    o_done    = 1'b0;
    o_bram_we = 1'b0;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_READ;
      S_READ:  w_next = S_LOAD;
      S_LOAD:  w_next = w_occupied ? S_DONE : S_SCAN;
      S_SCAN:  if (!w_is_opp && (r_dir == 3'd7)) w_next = S_APPLY;
      S_APPLY: w_next = (r_flip == 64'd0) ? S_DONE : S_WRITE;
      S_WRITE: begin
        o_bram_we = !i_reset;
        w_next    = S_DONE;
      end
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Move datapath: request capture, board load, ray scan and result build.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_dst_addr   <= 4'd0;
      r_row        <= 3'd0;
      r_col        <= 3'd0;
      r_player     <= 1'b0;
      r_board      <= '0;
      r_flip       <= 64'd0;
      r_pend       <= 64'd0;
      r_dir        <= 3'd0;
      r_cur_row    <= 3'd0;
      r_cur_col    <= 3'd0;
      r_legal      <= 1'b0;
      r_flip_count <= 5'd0;
      r_bram_addr  <= 4'd0;
      r_bram_din   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_dst_addr   <= i_dst_addr;
            r_row        <= i_row;
            r_col        <= i_col;
            r_player     <= i_player;
            r_bram_addr  <= i_src_addr;
            r_legal      <= 1'b0;
            r_flip_count <= 5'd0;
            r_flip       <= 64'd0;
            r_pend       <= 64'd0;
            r_dir        <= 3'd0;
          end
        end
        S_LOAD: begin
          r_board   <= i_bram_dout;
          r_cur_row <= r_row;
          r_cur_col <= r_col;
        end
        S_SCAN: begin
          if (w_is_opp) begin
            r_pend    <= r_pend | (64'd1 << w_cand_idx);
            r_cur_row <= w_cand_r[2:0];
            r_cur_col <= w_cand_c[2:0];
          end else begin
            if (w_is_own) r_flip <= r_flip | r_pend;
            r_pend    <= 64'd0;
            r_cur_row <= r_row;
            r_cur_col <= r_col;
            r_dir     <= r_dir + 3'd1;
          end
        end
        S_APPLY: begin
          if (r_flip != 64'd0) begin
            r_legal      <= 1'b1;
            r_flip_count <= popcount64(r_flip);
            r_bram_din   <= build_board(r_board, r_flip, w_tgt_idx, w_own_code);
            r_bram_addr  <= r_dst_addr;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_legal      = r_legal;
  assign o_flip_count = r_flip_count;
  assign o_bram_addr  = r_bram_addr;
  assign o_bram_din   = r_bram_din;

endmodule

// File: tb/tb_othello_move_engine.sv
// Bench for othello_move_engine: a 16 x 256 BRAM model, a game-rule model
// of the move, a per-cycle compare process and directed move scenarios.
module tb_othello_move_engine;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   src_addr;
  logic [3:0]   dst_addr;
  logic [2:0]   row;
  logic [2:0]   col;
  logic         player;
  logic         busy;
  logic         done;
  logic         legal;
  logic [4:0]   flip_count;
  logic         bram_we;
  logic [3:0]   bram_addr;
  logic [255:0] bram_din;
  logic [255:0] bram_dout;

  logic [255:0] mem [16];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_ctr  = 0;
  int t0       = 0;
  logic mon_on = 1'b0;

  logic         exp_legal;
  int           exp_fc;
  int           exp_done;
  int           exp_wr;
  logic [3:0]   exp_dst;
  logic [255:0] exp_board;

  othello_move_engine #(.MEM_SIZE(256)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start),
    .i_src_addr(src_addr), .i_dst_addr(dst_addr),
    .i_row(row), .i_col(col), .i_player(player),
    .o_busy(busy), .o_done(done), .o_legal(legal), .o_flip_count(flip_count),
    .o_bram_we(bram_we), .o_bram_addr(bram_addr), .o_bram_din(bram_din),
    .i_bram_dout(bram_dout)
  );

  always #5 clk = ~clk;

  // Synchronous BRAM, read-first.
  always @(posedge clk) begin
    if (bram_we) mem[bram_addr] <= bram_din;
    bram_dout <= mem[bram_addr];
  end

  always @(posedge clk) cyc_ctr <= cyc_ctr + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] put(input logic [255:0] b, input int r, input int c,
                                       input logic [3:0] nib);
    b[4*(r*8+c) +: 4] = nib;
    return b;
  endfunction

  function automatic logic [3:0] nib_of(input logic [255:0] b, input int r, input int c);
    return b[4*(r*8+c) +: 4];
  endfunction

  function automatic logic [1:0] cd(input logic [255:0] b, input int r, input int c);
    logic [1:0] v;
    v = b[4*(r*8+c) +: 2];
    return (v == 2'b11) ? 2'b00 : v;
  endfunction

  // Game-rule model: walk each ray from the target, count evaluations,
  // and derive legality, flips, result board and the done/write cycles.
  task automatic model(input logic [255:0] b, input int trow, input int tcol, input logic pl,
                       output logic lg, output int fc, output logic [255:0] nb,
                       output int dcyc, output int wcyc);
    int dr [8] = '{-1, -1, 0, 1, 1, 1, 0, -1};
    int dc [8] = '{ 0,  1, 1, 1, 0, -1, -1, -1};
    logic [1:0] own, opp;
    logic [3:0] pn;
    int scan, r, c, n;
    own = pl ? 2'b10 : 2'b01;
    opp = pl ? 2'b01 : 2'b10;
    pn  = {2'b00, own};
    nb = b; lg = 1'b0; fc = 0; wcyc = -1; scan = 0; dcyc = 0;
    if (cd(b, trow, tcol) != 2'b00) begin
      dcyc = 3;
      return;
    end
    for (int d = 0; d < 8; d++) begin
      r = trow + dr[d]; c = tcol + dc[d]; n = 0;
      forever begin
        scan++;
        if (r < 0 || r > 7 || c < 0 || c > 7) break;
        if (cd(b, r, c) == opp) begin
          n++; r += dr[d]; c += dc[d];
        end else begin
          if (cd(b, r, c) == own)
            for (int k = 1; k <= n; k++) begin
              nb = put(nb, trow + k*dr[d], tcol + k*dc[d], pn);
              fc++;
            end
          break;
        end
      end
    end
    if (fc > 0) begin
      lg = 1'b1; nb = put(nb, trow, tcol, pn); dcyc = scan + 5; wcyc = dcyc - 1;
    end else begin
      nb = b; dcyc = scan + 4;
    end
  endtask

  // Per-cycle compare of DUT outputs against the model during a move.
  always @(negedge clk) begin : monitor
    int k;
    if (mon_on) begin
      k = cyc_ctr - t0 + 1;
      check("done", done, k == exp_done);
      check("busy", busy, k <= exp_done);
      check("bram_we", bram_we, k == exp_wr);
      if (k == exp_wr) begin
        check("bram_addr", bram_addr, exp_dst);
        check("bram_din", bram_din, exp_board);
      end
      if (k == exp_done) check("flip_count", flip_count, exp_fc);
      if (k >= exp_done) check("legal", legal, exp_legal);
    end
  end

  task automatic issue(input int src, input int dst, input int r, input int c, input logic pl);
    @(posedge clk); #1;
    src_addr = 4'(src); dst_addr = 4'(dst); row = 3'(r); col = 3'(c); player = pl;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t0 = cyc_ctr;
  endtask

  task automatic do_move(input int src, input int dst, input int r, input int c,
                         input logic pl, input int poke);
    logic [255:0] old;
    logic got;
    old = mem[dst];
    model(mem[src], r, c, pl, exp_legal, exp_fc, exp_board, exp_done, exp_wr);
    exp_dst = 4'(dst);
    issue(src, dst, r, c, pl);
    mon_on = 1'b1;
    got = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      start = (n == poke);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    check("done_seen", got, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    mon_on = 1'b0;
    start  = 1'b0;
    check("dst_entry", mem[dst], exp_legal ? exp_board : old);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_legal"}, legal, 1'b0);
    check({tag, "_flip_count"}, flip_count, 5'd0);
    check({tag, "_bram_we"}, bram_we, 1'b0);
    check({tag, "_bram_addr"}, bram_addr, 4'd0);
    check({tag, "_bram_din"}, bram_din, 256'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [255:0] b0, bc, br, old;
    reset = 1'b1; start = 1'b0; src_addr = 4'd0; dst_addr = 4'd0;
    row = 3'd0; col = 3'd0; player = 1'b0;

    for (int i = 0; i < 16; i++) mem[i] = {64{4'(i) ^ 4'hC}};
    // Opening position with decorated upper bits on untouched squares.
    b0 = '0;
    b0 = put(b0, 3, 3, 4'h2); b0 = put(b0, 3, 4, 4'h1);
    b0 = put(b0, 4, 3, 4'h1); b0 = put(b0, 4, 4, 4'h2);
    b0 = put(b0, 7, 7, 4'hC); b0 = put(b0, 0, 5, 4'h4);
    mem[0] = b0;
    mem[5] = b0;
    // Corner case: black row (upper bits set) ended by white, black diagonal ended by white.
    bc = '0;
    for (int k = 1; k <= 6; k++) bc = put(bc, 0, k, 4'hD);
    bc = put(bc, 0, 7, 4'h2); bc = put(bc, 1, 1, 4'h1);
    bc = put(bc, 2, 2, 4'h1); bc = put(bc, 3, 3, 4'h2);
    mem[4] = bc;
    // Reserved target and a ray broken by a reserved square.
    br = '0;
    br = put(br, 4, 0, 4'h7); br = put(br, 4, 1, 4'h2);
    br = put(br, 4, 2, 4'h3); br = put(br, 4, 3, 4'h1);
    br = put(br, 3, 0, 4'h2); br = put(br, 2, 0, 4'h1);
    mem[6] = br;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Opening: black at (2,3) flips (3,3).
    do_move(0, 1, 2, 3, 1'b0, 0);
    check("open_model_done_cycle", exp_done, 14);
    check("open_flip_count", flip_count, 5'd1);
    check("open_legal", legal, 1'b1);
    check("open_target", nib_of(mem[1], 2, 3), 4'h1);
    check("open_flipped", nib_of(mem[1], 3, 3), 4'h1);
    check("open_preserved", nib_of(mem[1], 7, 7), 4'hC);

    // Opening: black at (0,0) is illegal, no write.
    do_move(0, 2, 0, 0, 1'b0, 0);
    check("corner_illegal_done_cycle", exp_done, 12);
    check("corner_illegal_legal", legal, 1'b0);
    check("corner_illegal_fc", flip_count, 5'd0);

    // Occupied target: done three cycles after start.
    do_move(0, 11, 3, 3, 1'b0, 0);
    check("occupied_done_cycle", exp_done, 3);
    check("occupied_legal", legal, 1'b0);

    // White corner move flipping a full row and a diagonal.
    do_move(4, 9, 0, 0, 1'b1, 0);
    check("corner_model_fc", exp_fc, 8);
    check("corner_done_cycle", exp_done, 21);
    check("corner_fc", flip_count, 5'd8);
    check("corner_row_flip", nib_of(mem[9], 0, 3), 4'h2);
    check("corner_diag_flip", nib_of(mem[9], 2, 2), 4'h2);
    check("corner_anchor", nib_of(mem[9], 0, 7), 4'h2);

    // Reserved target treated as empty; reserved square breaks a ray.
    do_move(6, 10, 4, 0, 1'b0, 0);
    check("reserved_fc", flip_count, 5'd1);
    check("reserved_target", nib_of(mem[10], 4, 0), 4'h1);
    check("reserved_unflipped", nib_of(mem[10], 4, 1), 4'h2);
    check("reserved_flipped", nib_of(mem[10], 3, 0), 4'h1);

    // In-place update with a start pulse while busy (must be ignored).
    do_move(5, 5, 2, 4, 1'b1, 5);
    check("inplace_flip", nib_of(mem[5], 3, 4), 4'h2);
    check("inplace_target", nib_of(mem[5], 2, 4), 4'h2);
    check("inplace_other", nib_of(mem[5], 4, 3), 4'h1);

    // Reset asserted during the WRITE cycle.
    old = mem[12];
    model(mem[0], 2, 3, 1'b0, exp_legal, exp_fc, exp_board, exp_done, exp_wr);
    issue(0, 12, 2, 3, 1'b0);
    repeat (exp_wr - 1) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("rstwr_addr", bram_addr, 4'd12);
    check("rstwr_din", bram_din, exp_board);
    check("rstwr_we", bram_we, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_reset");
    @(posedge clk); #1;
    check("rstwr_dst_unchanged", mem[12], old);

    // Normal operation after the aborted move: black at (4,5).
    do_move(0, 13, 4, 5, 1'b0, 0);
    check("after_reset_fc", flip_count, 5'd1);
    check("after_reset_flip", nib_of(mem[13], 4, 4), 4'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
